// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/data memory-port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    // Owner of a grant decided in IDLE
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Store code driven to memory on fetch transactions
    localparam logic [1:0] MWRITE_NONE = 2'b00;

    // Fetch-side address/data width
    localparam int unsigned IADR_W = 32;

endpackage

// File: rtl/mem_arb_wdog.sv
// Per-transaction watchdog: counts busy cycles since the grant and flags
// the busy cycle in which TIMEOUT cycles have already elapsed.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    // Count busy cycles; expired is registered so it is high exactly when wait_cnt==TIMEOUT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            expired  <= 1'b0;
        end else if (clr || !run) begin
            wait_cnt <= '0;
            expired  <= 1'b0;
        end else if (!expired) begin
            wait_cnt <= wait_cnt + CW'(1);
            expired  <= (wait_cnt == CW'(TIMEOUT - 1));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache refill (I) and CPU data (D).
// D has fixed priority, bounded by a starvation counter for pending fetches;
// a watchdog aborts transactions the memory never answers.
// Optional build macro: ARB_PERF_CNT_EN adds grant/abort performance counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N          = 64,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [IADR_W-1:0] i_adr,
    output logic [IADR_W-1:0] i_rdata,
    output logic              i_val,
    output logic              i_abort,
    input  logic              d_req,
    input  logic [N-1:0]      d_adr,
    input  logic [N-1:0]      d_wdata,
    input  logic [1:0]        d_write,
    output logic [N-1:0]      d_rdata,
    output logic              d_val,
    output logic              d_abort,
    output logic              m_req,
    output logic [N-1:0]      m_adr,
    output logic [N-1:0]      m_wdata,
    output logic [1:0]        m_write,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_igrant,
    output logic [31:0]       perf_dgrant,
    output logic [31:0]       perf_abort,
`endif
    input  logic [N-1:0]      m_rdata,
    input  logic              m_val
);

    localparam int unsigned    SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t        state;
    arb_state_t        state_nxt;
    owner_t            grant_own;
    logic              grant;
    logic              busy;
    logic              expired;
    logic              i_elig;
    logic              d_elig;
    logic [SW-1:0]     starve_cnt;
    logic [SW-1:0]     starve_nxt;

    logic [IADR_W-1:0] i_rdata_nxt;
    logic              i_val_nxt;
    logic              i_abort_nxt;
    logic [N-1:0]      d_rdata_nxt;
    logic              d_val_nxt;
    logic              d_abort_nxt;
    logic              m_req_nxt;
    logic [N-1:0]      m_adr_nxt;
    logic [N-1:0]      m_wdata_nxt;
    logic [1:0]        m_write_nxt;

    // A requester whose completion/abort pulse is showing this cycle is not a new request
    assign i_elig = i_req && !i_val && !i_abort;
    assign d_elig = d_req && !d_val && !d_abort;
    assign busy   = (state != IDLE);

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (grant),
        .run     (busy),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decision; D wins unless a pending fetch has been starved out
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_own = OWN_D;
        case (state)
            IDLE: begin
                if (d_elig && !(i_elig && (starve_cnt == STARVE_TOP))) begin
                    grant     = 1'b1;
                    grant_own = OWN_D;
                    state_nxt = DBUSY;
                end else if (i_elig) begin
                    grant     = 1'b1;
                    grant_own = OWN_I;
                    state_nxt = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (m_val || expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the starvation counter
    always_comb begin
        i_rdata_nxt = i_rdata;
        i_val_nxt   = 1'b0;
        i_abort_nxt = 1'b0;
        d_rdata_nxt = d_rdata;
        d_val_nxt   = 1'b0;
        d_abort_nxt = 1'b0;
        m_req_nxt   = m_req;
        m_adr_nxt   = m_adr;
        m_wdata_nxt = m_wdata;
        m_write_nxt = m_write;
        starve_nxt  = starve_cnt;

        if (grant) begin
            m_req_nxt = 1'b1;
            if (grant_own == OWN_D) begin
                m_adr_nxt   = d_adr;
                m_wdata_nxt = d_wdata;
                m_write_nxt = d_write;
                if (i_req) begin
                    starve_nxt = (starve_cnt == STARVE_TOP) ? starve_cnt : starve_cnt + SW'(1);
                end else begin
                    starve_nxt = '0;
                end
            end else begin
                m_adr_nxt   = N'(i_adr);
                m_wdata_nxt = '0;
                m_write_nxt = MWRITE_NONE;
                starve_nxt  = '0;
            end
        end else if (busy) begin
            // Completion beats a same-cycle timeout
            if (m_val) begin
                m_req_nxt = 1'b0;
                if (state == IBUSY) begin
                    i_val_nxt   = 1'b1;
                    i_rdata_nxt = m_rdata[IADR_W-1:0];
                end else begin
                    d_val_nxt   = 1'b1;
                    d_rdata_nxt = m_rdata;
                end
            end else if (expired) begin
                m_req_nxt = 1'b0;
                if (state == IBUSY) begin
                    i_abort_nxt = 1'b1;
                end else begin
                    d_abort_nxt = 1'b1;
                end
            end
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_rdata    <= '0;
            i_val      <= 1'b0;
            i_abort    <= 1'b0;
            d_rdata    <= '0;
            d_val      <= 1'b0;
            d_abort    <= 1'b0;
            m_req      <= 1'b0;
            m_adr      <= '0;
            m_wdata    <= '0;
            m_write    <= MWRITE_NONE;
            starve_cnt <= '0;
        end else begin
            i_rdata    <= i_rdata_nxt;
            i_val      <= i_val_nxt;
            i_abort    <= i_abort_nxt;
            d_rdata    <= d_rdata_nxt;
            d_val      <= d_val_nxt;
            d_abort    <= d_abort_nxt;
            m_req      <= m_req_nxt;
            m_adr      <= m_adr_nxt;
            m_wdata    <= m_wdata_nxt;
            m_write    <= m_write_nxt;
            starve_cnt <= starve_nxt;
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Free-running grant and timeout counters, wrapping at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_igrant <= '0;
            perf_dgrant <= '0;
            perf_abort  <= '0;
        end else begin
            if (grant && (grant_own == OWN_I)) begin
                perf_igrant <= perf_igrant + 32'd1;
            end
            if (grant && (grant_own == OWN_D)) begin
                perf_dgrant <= perf_dgrant + 32'd1;
            end
            if (busy && !m_val && expired) begin
                perf_abort <= perf_abort + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned N  = 64;
    localparam int          SM = 4;
    localparam int          TO = 255;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [31:0]   i_adr = '0;
    logic [31:0]   i_rdata;
    logic          i_val;
    logic          i_abort;
    logic          d_req = 1'b0;
    logic [N-1:0]  d_adr = '0;
    logic [N-1:0]  d_wdata = '0;
    logic [1:0]    d_write = '0;
    logic [N-1:0]  d_rdata;
    logic          d_val;
    logic          d_abort;
    logic          m_req;
    logic [N-1:0]  m_adr;
    logic [N-1:0]  m_wdata;
    logic [1:0]    m_write;
    logic [N-1:0]  m_rdata = '0;
    logic          m_val = 1'b0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_igrant;
    logic [31:0]   perf_dgrant;
    logic [31:0]   perf_abort;
`endif

    mem_arbiter #(.N(N), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_adr   (i_adr),
        .i_rdata (i_rdata),
        .i_val   (i_val),
        .i_abort (i_abort),
        .d_req   (d_req),
        .d_adr   (d_adr),
        .d_wdata (d_wdata),
        .d_write (d_write),
        .d_rdata (d_rdata),
        .d_val   (d_val),
        .d_abort (d_abort),
        .m_req   (m_req),
        .m_adr   (m_adr),
        .m_wdata (m_wdata),
        .m_write (m_write),
`ifdef ARB_PERF_CNT_EN
        .perf_igrant (perf_igrant),
        .perf_dgrant (perf_dgrant),
        .perf_abort  (perf_abort),
`endif
        .m_rdata (m_rdata),
        .m_val   (m_val)
    );

    always #5 clk = ~clk;

    // Model: who owns the port (0 none, 1 fetch, 2 data), busy cycles elapsed, starvation count
    int           owner;
    int           waited;
    int           starve;
    int           lat;
    int           next_lat;
    int           n_igrant;
    int           n_dgrant;
    int           n_abort;
    logic [N-1:0] mem_data;
    bit           e_i_val, e_i_abort, e_d_val, e_d_abort, e_m_req;
    logic [31:0]  e_i_rdata;
    logic [N-1:0] e_d_rdata, e_m_adr, e_m_wdata;
    logic [1:0]   e_m_write;

    int checks = 0;
    int fails  = 0;
    int cyc;
    int exp_d[6] = '{1, 1, 1, 1, 0, 1};

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; waited = 0; starve = 0; lat = 0;
        n_igrant = 0; n_dgrant = 0; n_abort = 0;
        e_i_val = 0; e_i_abort = 0; e_d_val = 0; e_d_abort = 0; e_m_req = 0;
        e_i_rdata = '0; e_d_rdata = '0; e_m_adr = '0; e_m_wdata = '0; e_m_write = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_edge();
        bit ie, de;
        ie = i_req && !e_i_val && !e_i_abort;
        de = d_req && !d_val_exp_guard();
        e_i_val = 0; e_i_abort = 0; e_d_val = 0; e_d_abort = 0;
        if (owner == 0) begin
            if (de && !(ie && starve == SM)) begin
                owner = 2; n_dgrant++;
                e_m_adr = d_adr; e_m_wdata = d_wdata; e_m_write = d_write;
                starve = i_req ? ((starve < SM) ? starve + 1 : SM) : 0;
            end else if (ie) begin
                owner = 1; n_igrant++;
                e_m_adr = {32'h0, i_adr}; e_m_wdata = '0; e_m_write = 2'b00;
                starve = 0;
            end
            if (owner != 0) begin
                e_m_req = 1; waited = 0; lat = next_lat;
            end
        end else if (m_val) begin
            if (owner == 1) begin e_i_val = 1; e_i_rdata = m_rdata[31:0]; end
            else begin e_d_val = 1; e_d_rdata = m_rdata; end
            e_m_req = 0; owner = 0;
        end else if (waited == TO) begin
            if (owner == 1) e_i_abort = 1; else e_d_abort = 1;
            e_m_req = 0; owner = 0; n_abort++;
        end else begin
            waited++;
        end
    endtask

    // Data side is blocked in the cycle its own completion or abort is visible
    function automatic bit d_val_exp_guard();
        return e_d_val || e_d_abort;
    endfunction

    task automatic compare_all();
        check("i_val",   64'(i_val),   64'(e_i_val));
        check("i_abort", 64'(i_abort), 64'(e_i_abort));
        check("d_val",   64'(d_val),   64'(e_d_val));
        check("d_abort", 64'(d_abort), 64'(e_d_abort));
        check("m_req",   64'(m_req),   64'(e_m_req));
        check("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
        check("d_rdata", d_rdata, e_d_rdata);
        check("one_pulse", 64'((32'(i_val) + 32'(i_abort) + 32'(d_val) + 32'(d_abort)) <= 1), 64'd1);
        if (e_m_req) begin
            check("m_adr",   m_adr,   e_m_adr);
            check("m_wdata", m_wdata, e_m_wdata);
            check("m_write", 64'(m_write), 64'(e_m_write));
        end
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs compared mid-cycle
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Memory responder: answers after the chosen latency, optionally strobes while idle
    task automatic auto_mem(input int stale_pct);
        if (owner != 0) m_val = (waited == lat);
        else            m_val = (int'($urandom_range(99)) < stale_pct);
        m_rdata = mem_data;
    endtask

    task automatic run_until_done(input int budget, output int n);
        n = 0;
        do begin
            auto_mem(0);
            step();
            n++;
        end while (!(i_val || i_abort || d_val || d_abort) && n < budget);
        m_val = 1'b0;
        check("done_seen", 64'(i_val || i_abort || d_val || d_abort), 64'd1);
    endtask

    initial begin
        model_reset();
        next_lat = 0;
        mem_data = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Load at 0x40, memory latency 3: val 5 cycles after the request
        d_adr = 64'h40; d_wdata = '0; d_write = 2'b00; d_req = 1'b1;
        next_lat = 3; mem_data = 64'h1122_3344_5566_7788; m_val = 1'b0;
        step();
        check("t1_mreq", 64'(m_req), 64'd1);
        check("t1_madr", m_adr, 64'h40);
        run_until_done(50, cyc);
        check("t1_latency", 64'(cyc + 1), 64'd5);
        check("t1_dval", 64'(d_val), 64'd1);
        check("t1_rdata", d_rdata, 64'h1122_3344_5566_7788);
        d_req = 1'b0; step();

        // I and D together: D first, then I
        i_adr = 32'h1000; d_adr = 64'h80; d_wdata = 64'h55; d_write = 2'b11;
        i_req = 1'b1; d_req = 1'b1; next_lat = 1; mem_data = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        check("t2_first_d", m_adr, 64'h80);
        run_until_done(50, cyc);
        d_req = 1'b0; mem_data = 64'h0123_4567_89AB_CDEF; next_lat = 2;
        step();
        check("t2_then_i", m_adr, 64'h1000);
        check("t2_i_wdata", m_wdata, 64'h0);
        check("t2_i_write", 64'(m_write), 64'h0);
        run_until_done(50, cyc);
        check("t2_i_rdata", 64'(i_rdata), 64'h89AB_CDEF);
        i_req = 1'b0; step();

        // Starvation bound: four D wins with fetch pending, then fetch, then D again
        for (int k = 0; k < 6; k++) begin
            d_adr = 64'h200 + 64'(k); i_adr = 32'h300 + 32'(k);
            d_req = 1'b1; i_req = 1'b1; next_lat = k % 3; mem_data = 64'(k) * 64'h101;
            m_val = 1'b0;
            step();
            check("t3_winner", m_adr, (exp_d[k] == 1) ? d_adr : {32'h0, i_adr});
            run_until_done(50, cyc);
            i_req = 1'b0; d_req = 1'b0; step();
        end

        // Silent memory: abort once TIMEOUT busy cycles have elapsed
        d_adr = 64'h500; d_req = 1'b1; next_lat = 1000;
        run_until_done(300, cyc);
        check("t4_abort_lat", 64'(cyc), 64'(TO + 2));
        check("t4_abort", 64'(d_abort), 64'd1);
        check("t4_mreq_drop", 64'(m_req), 64'd0);
        d_req = 1'b0; step();
        i_adr = 32'h600; i_req = 1'b1; next_lat = 2; mem_data = 64'h5555_6666_7777_8888;
        run_until_done(50, cyc);
        check("t4_ival", 64'(i_val), 64'd1);
        check("t4_irdata", 64'(i_rdata), 64'h7777_8888);
        i_req = 1'b0; step();

        // Completion on the timeout cycle wins; stale strobe in idle is ignored
        d_adr = 64'h640; d_req = 1'b1; next_lat = TO; mem_data = 64'hCAFE_F00D_0000_0001;
        run_until_done(300, cyc);
        check("t5_lat", 64'(cyc), 64'(TO + 2));
        check("t5_dval", 64'(d_val), 64'd1);
        check("t5_no_abort", 64'(d_abort), 64'd0);
        d_req = 1'b0; step();
        m_val = 1'b1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        m_val = 1'b0;
        check("t5_stale_rdata", d_rdata, 64'hCAFE_F00D_0000_0001);
        check("t5_stale_mreq", 64'(m_req), 64'd0);

        // Reset mid-DBUSY with starvation saturated; afterwards D must win again
        for (int k = 0; k < 3; k++) begin
            d_adr = 64'h900 + 64'(k); i_adr = 32'hA00; d_req = 1'b1; i_req = 1'b1; next_lat = 1;
            run_until_done(50, cyc);
            i_req = 1'b0; d_req = 1'b0; step();
        end
        d_adr = 64'h980; i_req = 1'b1; d_req = 1'b1; next_lat = 1000; m_val = 1'b0;
        step();
        check("t6_fourth_d", m_adr, 64'h980);
        step(); step(); step();
        #2 reset = 1'b0;
        #1;
        check("t6_rst_mreq",  64'(m_req), 64'd0);
        check("t6_rst_dval",  64'(d_val | d_abort | i_val | i_abort), 64'd0);
        check("t6_rst_madr",  m_adr, 64'd0);
        check("t6_rst_mwd",   m_wdata | 64'(m_write), 64'd0);
        check("t6_rst_rdata", d_rdata | 64'(i_rdata), 64'd0);
        model_reset();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        d_adr = 64'h700; i_adr = 32'h800; i_req = 1'b1; d_req = 1'b1; next_lat = 1;
        step();
        check("t6_starve_clr", m_adr, 64'h700);
        run_until_done(50, cyc);
        d_req = 1'b0; step();
        run_until_done(50, cyc);
        i_req = 1'b0; step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if (i_req) begin
                if (e_i_val || e_i_abort) begin
                    if ($urandom_range(1) == 1) i_req = 1'b0; else i_adr = $urandom;
                end else if ($urandom_range(39) == 0) begin
                    i_req = 1'b0;
                end
            end else if ($urandom_range(3) == 0) begin
                i_req = 1'b1; i_adr = $urandom;
            end
            if (d_req) begin
                if (e_d_val || e_d_abort) begin
                    if ($urandom_range(1) == 1) d_req = 1'b0;
                    else begin d_adr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; d_write = 2'($urandom_range(3)); end
                end
            end else if ($urandom_range(2) == 0) begin
                d_req = 1'b1; d_adr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom}; d_write = 2'($urandom_range(3));
            end
            next_lat = ($urandom_range(149) == 0) ? 1000 : int'($urandom_range(6));
            mem_data = {$urandom, $urandom};
            auto_mem(10);
            step();
        end

        // Drain
        i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 300 && owner != 0; c++) begin
            auto_mem(0);
            step();
        end
        m_val = 1'b0;
        step(); step();
        check("drained", 64'(m_req), 64'd0);
`ifdef ARB_PERF_CNT_EN
        check("perf_igrant", 64'(perf_igrant), 64'(n_igrant));
        check("perf_dgrant", 64'(perf_dgrant), 64'(n_dgrant));
        check("perf_abort",  64'(perf_abort),  64'(n_abort));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
